bus_peripheral: RTL and testbench

- Memory-mapped peripheral slave that sits directly downstream of the pipelined core's MEM-stage data port.
- It consumes the core's address, read/write strobes and write data, and returns read data in the same cycle for MEM-stage load forwarding.
- It contains an auto-reload timer, an LED register, a switch input and a buffered UART transmitter.
- Its oInterrupt output drives the core's iInterrupt.

---
 rtl/bus_peripheral.sv | 232 +++++++++++++++++++++++
 tb/tb_bus_peripheral.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_peripheral.sv
`default_nettype none
// ============================================================================
// Module  : bus_peripheral
// Brief   : MEM-stage memory-mapped slave with timer, LEDs, switches, UART TX.
// Revision: 1.0 - initial release
// ============================================================================
module bus_peripheral #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] iMemAddr,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [31:0] iMemWriteData,
  output logic [31:0] oMemReadData,
  input  logic [7:0]  iSwitch,
  output logic [7:0]  oLed,
  output logic        oUartTx,
  output logic        oInterrupt
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  localparam logic [2:0] OFF_TH     = 3'd0;
  localparam logic [2:0] OFF_TL     = 3'd1;
  localparam logic [2:0] OFF_TCON   = 3'd2;
  localparam logic [2:0] OFF_LED    = 3'd3;
  localparam logic [2:0] OFF_SWITCH = 3'd4;
  localparam logic [2:0] OFF_TXD    = 3'd6;
  localparam logic [2:0] OFF_UCON   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Bus decode
  logic       sel;
  logic [2:0] off;
  logic       wr_th, wr_tl, wr_tcon, wr_led, wr_txd, wr_ucon, rd_ucon;
  logic       unused_addr_lsbs;

  assign sel     = (iMemAddr[31:5] == 27'h2000000);
  assign off     = iMemAddr[4:2];
  assign wr_th   = iMemWrite & sel & (off == OFF_TH);
  assign wr_tl   = iMemWrite & sel & (off == OFF_TL);
  assign wr_tcon = iMemWrite & sel & (off == OFF_TCON);
  assign wr_led  = iMemWrite & sel & (off == OFF_LED);
  assign wr_txd  = iMemWrite & sel & (off == OFF_TXD);
  assign wr_ucon = iMemWrite & sel & (off == OFF_UCON);
  assign rd_ucon = iMemRead  & sel & (off == OFF_UCON);
  assign unused_addr_lsbs = ^iMemAddr[1:0];

  // Timer and LED registers
  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [7:0]  led;
  logic        tl_wrap;

  assign tl_wrap = (tl == 32'hFFFF_FFFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
      led  <= '0;
    end else begin
      if (wr_th) th <= iMemWriteData;
      if (wr_tl)
        tl <= iMemWriteData;
      else if (tcon[0])
        tl <= tl_wrap ? th : tl + 32'd1;
      if (wr_tcon)
        tcon <= iMemWriteData[2:0];
      else if (tcon[0] && tl_wrap && tcon[1])
        tcon[2] <= 1'b1;
      if (wr_led) led <= iMemWriteData[7:0];
    end
  end

  // UART transmitter state
  uart_state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  buf_data, buf_n;
  logic        full, full_n;
  logic        done, done_n;
  logic        tx, tx_n;
  logic        ucon_ie;
  logic        bit_end;
  logic        take;
  logic        set_done;

  assign bit_end = (cnt == BIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      buf_data <= '0;
      full     <= 1'b0;
      done     <= 1'b0;
      tx       <= 1'b1;
      ucon_ie  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shift    <= shift_n;
      buf_data <= buf_n;
      full     <= full_n;
      done     <= done_n;
      tx       <= tx_n;
      if (wr_ucon) ucon_ie <= iMemWriteData[3];
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shift_n  = shift;
    buf_n    = buf_data;
    full_n   = full;
    done_n   = done;
    take     = 1'b0;
    set_done = 1'b0;

    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (full) begin
          take    = 1'b1;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = ST_DATA;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            state_n = ST_STOP;
          end else begin
            idx_n   = idx + 3'd1;
            shift_n = shift >> 1;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_n    = '0;
          set_done = 1'b1;
          if (full) begin
            take    = 1'b1;
            state_n = ST_START;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase

    if (take) begin
      shift_n = buf_data;
      full_n  = 1'b0;
    end

    // The slot vacated by a transfer to the shift register can be refilled on the same edge
    if (wr_txd && (!full || take)) begin
      buf_n  = iMemWriteData[7:0];
      full_n = 1'b1;
    end

    if (rd_ucon)  done_n = 1'b0;
    if (set_done) done_n = 1'b1;

    case (state_n)
      ST_START: tx_n = 1'b0;
      ST_DATA:  tx_n = shift_n[0];
      default:  tx_n = 1'b1;
    endcase
  end

  // Read path
  logic [3:0] ucon;
  assign ucon = {ucon_ie, done, full, (state != ST_IDLE)};

  always_comb begin
    oMemReadData = '0;
    if (iMemRead && sel) begin
      case (off)
        OFF_TH:     oMemReadData = th;
        OFF_TL:     oMemReadData = tl;
        OFF_TCON:   oMemReadData = {29'd0, tcon};
        OFF_LED:    oMemReadData = {24'd0, led};
        OFF_SWITCH: oMemReadData = {24'd0, iSwitch};
        OFF_UCON:   oMemReadData = {28'd0, ucon};
        default:    oMemReadData = '0;
      endcase
    end
  end

  assign oLed       = led;
  assign oUartTx    = tx;
  assign oInterrupt = tcon[2] | (ucon_ie & done);

endmodule
`default_nettype wire

// File: tb/tb_bus_peripheral.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_peripheral
// Brief   : Directed scoreboard bench for bus_peripheral (CLKS_PER_BIT = 4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_bus_peripheral;

  localparam int CPB = 4;
  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_RSV  = 32'h4000_0014;
  localparam logic [31:0] A_TXD  = 32'h4000_0018;
  localparam logic [31:0] A_UCON = 32'h4000_001C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] iMemAddr;
  logic        iMemRead;
  logic        iMemWrite;
  logic [31:0] iMemWriteData;
  logic [31:0] oMemReadData;
  logic [7:0]  iSwitch;
  logic [7:0]  oLed;
  logic        oUartTx;
  logic        oInterrupt;

  bus_peripheral #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .iMemAddr     (iMemAddr),
    .iMemRead     (iMemRead),
    .iMemWrite    (iMemWrite),
    .iMemWriteData(iMemWriteData),
    .oMemReadData (oMemReadData),
    .iSwitch      (iSwitch),
    .oLed         (oLed),
    .oUartTx      (oUartTx),
    .oInterrupt   (oInterrupt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t rd_q[$];
  logic tx_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic sb_compare(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (rd_q.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty: observed %h required an expectation", obs);
    end else begin
      e = rd_q.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    exp_t e;
    e.tag = tag;
    e.val = exp_v;
    rd_q.push_back(e);
    sb_compare(obs);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_v);
    exp_t e;
    e.tag = tag;
    e.val = exp_v;
    rd_q.push_back(e);
    iMemAddr = addr;
    iMemRead = 1'b1;
    #1;
    sb_compare(oMemReadData);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    iMemRead      = 1'b0;
    iMemAddr      = addr;
    iMemWriteData = data;
    iMemWrite     = 1'b1;
    @(negedge clk);
    iMemWrite     = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
    iMemRead  = 1'b0;
    iMemWrite = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] b);
    for (int i = 0; i < CPB; i++) tx_q.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < CPB; i++) tx_q.push_back(b[k]);
    for (int i = 0; i < CPB; i++) tx_q.push_back(1'b1);
  endtask

  task automatic tx_sample();
    logic e;
    n_cmp++;
    if (tx_q.size() == 0) begin
      n_err++;
      $error("FAIL tx_empty: observed %b required an expectation", oUartTx);
    end else begin
      e = tx_q.pop_front();
      assert (oUartTx === e) else begin
        n_err++;
        $error("FAIL uart_tx(left %0d): observed %b expected %b", tx_q.size(), oUartTx, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; iMemAddr = '0; iMemRead = 1'b0; iMemWrite = 1'b0;
    iMemWriteData = '0; iSwitch = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state and read map
    rd("rst_th",   A_TH,   32'h0);
    rd("rst_tl",   A_TL,   32'h0);
    rd("rst_tcon", A_TCON, 32'h0);
    rd("rst_led",  A_LED,  32'h0);
    rd("rst_sw",   A_SW,   32'h0000_00A5);
    rd("rst_txd",  A_TXD,  32'h0);
    rd("rst_rsv",  A_RSV,  32'h0);
    rd("rst_ucon", A_UCON, 32'h0);
    rd("out_of_map", 32'h4000_0030, 32'h0);
    chk("rst_tx",  {31'd0, oUartTx},    32'h1);
    chk("rst_irq", {31'd0, oInterrupt}, 32'h0);
    iMemRead = 1'b0; iMemAddr = A_SW; #1;
    chk("no_read_zero", oMemReadData, 32'h0);

    // LED, ignored writes, address LSBs ignored
    wr(A_LED, 32'hFFFF_FF3C);
    rd("led_rd", A_LED, 32'h3C);
    chk("led_pin", {24'd0, oLed}, 32'h3C);
    wr(A_SW, 32'h0000_00FF);
    wr(32'h0000_000C, 32'h0000_0077);
    rd("sw_ro", A_SW, 32'hA5);
    rd("led_lsb_addr", 32'h4000_000F, 32'h3C);

    // Timer wrap and interrupt
    wr(A_TH, 32'hFFFF_FFF0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    rd("tl_start", A_TL, 32'hFFFF_FFFE);
    chk("irq_pre", {31'd0, oInterrupt}, 32'h0);
    cyc();
    rd("tl_max", A_TL, 32'hFFFF_FFFF);
    cyc();
    rd("tl_reload", A_TL, 32'hFFFF_FFF0);
    rd("tcon_irq", A_TCON, 32'h7);
    chk("irq_timer", {31'd0, oInterrupt}, 32'h1);
    wr(A_TCON, 32'h3);
    rd("tcon_clr", A_TCON, 32'h3);
    chk("irq_clr", {31'd0, oInterrupt}, 32'h0);
    rd("tl_post", A_TL, 32'hFFFF_FFF1);

    // Bus write beats counting
    wr(A_TL, 32'h5);
    rd("tl_wr_wins", A_TL, 32'h5);
    cyc();
    rd("tl_count", A_TL, 32'h6);
    wr(A_TCON, 32'h0);
    rd("tl_stop", A_TL, 32'h7);
    cyc();
    rd("tl_hold", A_TL, 32'h7);

    // Single UART frame
    push_frame(8'h55);
    wr(A_TXD, 32'h55);
    rd("ucon_full", A_UCON, 32'h2);
    for (int i = 0; i < 10 * CPB; i++) begin
      cyc();
      tx_sample();
    end
    cyc();
    rd("ucon_done", A_UCON, 32'h4);
    chk("irq_no_ie", {31'd0, oInterrupt}, 32'h0);
    cyc();
    rd("ucon_rdclr", A_UCON, 32'h0);

    // Back-to-back bytes, third dropped
    wr(A_UCON, 32'h8);
    push_frame(8'h01);
    wr(A_TXD, 32'h01);
    rd("ucon_b2b_0", A_UCON, 32'hA);
    push_frame(8'h02);
    wr(A_TXD, 32'h02);
    tx_sample();
    rd("ucon_b2b_1", A_UCON, 32'hB);
    wr(A_TXD, 32'h03);
    tx_sample();
    rd("ucon_b2b_2", A_UCON, 32'hB);
    for (int i = 0; i < 20 * CPB - 2; i++) begin
      cyc();
      tx_sample();
    end
    cyc();
    chk("tx_idle", {31'd0, oUartTx}, 32'h1);
    chk("irq_done", {31'd0, oInterrupt}, 32'h1);
    rd("ucon_b2b_end", A_UCON, 32'hC);
    cyc();
    rd("ucon_b2b_clr", A_UCON, 32'h8);
    chk("irq_done_clr", {31'd0, oInterrupt}, 32'h0);
    cyc();
    chk("dropped_byte", {31'd0, oUartTx}, 32'h1);
    rd("ucon_idle", A_UCON, 32'h8);

    // Reset during DATA
    wr(A_TXD, 32'hA5);
    repeat (9) cyc();
    chk("tx_mid_data", {31'd0, oUartTx}, 32'h0);
    reset = 1'b1;
    #1;
    chk("tx_async_rst", {31'd0, oUartTx}, 32'h1);
    rd("ucon_rst", A_UCON, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    iMemRead = 1'b0;
    push_frame(8'h3C);
    wr(A_TXD, 32'h3C);
    for (int i = 0; i < 10 * CPB; i++) begin
      cyc();
      tx_sample();
    end
    cyc();
    rd("ucon_post_rst", A_UCON, 32'h4);
    chk("tx_q_drained", tx_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
